// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the cache-line memory controller.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN (host-silence watchdog).
package mem_ctrl_pkg;

    localparam int LINE_BITS  = 512;
    localparam int BEAT_BITS  = 64;
    localparam int BEATS      = 8;
    localparam int BEAT_IDX_W = 3;
    localparam int ADDR_W     = 64;
    localparam int LINE_OFS_W = 6;

    // Operation codes from the MMU; 2'b10 is deliberately left out as illegal.
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b11
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_BEAT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_BEAT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Clear the byte offset so the host always sees a line-aligned address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~{{(ADDR_W-LINE_OFS_W){1'b0}}, {LINE_OFS_W{1'b1}}};
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the MMU/host environment and mem_ctrl.
// Handshakes: an op is accepted on a cycle where ready=1 and mem_op is READ or
// WRITE; a host request is taken on the cycle host_gnt=1 while the request is
// high; a beat moves on each host_rd_valid (read) or host_wr_ack (write) cycle
// in the matching beat state. dbg_state/dbg_beat expose the FSM for checkers.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN (drives tx_err).
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic [1:0]           mem_op;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [LINE_BITS-1:0] wr_line;
    logic                 ready;
    logic                 tx_done;
    logic [LINE_BITS-1:0] rd_line;
    logic                 tx_err;
    logic [ADDR_W-1:0]    host_addr;
    logic                 host_rd_req;
    logic                 host_wr_req;
    logic                 host_gnt;
    logic                 host_rd_valid;
    logic [BEAT_BITS-1:0] host_rd_data;
    logic [BEAT_BITS-1:0] host_wr_data;
    logic                 host_wr_ack;
    state_t               dbg_state;
    logic [BEAT_IDX_W-1:0] dbg_beat;

    // Controller side.
    modport slave (
        input  mem_op, cpu_addr, wr_line, host_gnt, host_rd_valid, host_rd_data, host_wr_ack,
        output ready, tx_done, rd_line, tx_err, host_addr, host_rd_req, host_wr_req,
               host_wr_data, dbg_state, dbg_beat
    );

    // Environment side (MMU plus host model).
    modport master (
        output mem_op, cpu_addr, wr_line, host_gnt, host_rd_valid, host_rd_data, host_wr_ack,
        input  ready, tx_done, rd_line, tx_err, host_addr, host_rd_req, host_wr_req,
               host_wr_data, dbg_state, dbg_beat
    );

endinterface

// File: rtl/mem_ctrl_wdog.sv
// Host-silence watchdog: counts cycles spent waiting in a request/beat state
// and flags expiry once the count reaches TIMEOUT_CYCLES-1.
// Only instantiated when MEM_CTRL_TIMEOUT_EN is defined.
module mem_ctrl_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_clear,
    output logic o_expire
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Restart on any progress; saturate at the limit so expiry cannot wrap away.
    always_ff @(posedge clk) begin
        if (rst_n || !i_active || i_clear) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire = i_active && (r_count == LIMIT);

endmodule

// File: rtl/mem_ctrl.sv
// Cache-line memory controller: takes one READ/WRITE op from the MMU, issues a
// host request for the line-aligned address and moves eight 64-bit beats.
// Reset input rst_n is active-high despite its name.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN adds a watchdog that aborts a
// transaction with a tx_err pulse after TIMEOUT_CYCLES silent host cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_ctrl_if.slave bus
);

    state_t                r_state;
    state_t                w_state_next;
    logic [BEAT_IDX_W-1:0] r_beat;
    logic [BEAT_IDX_W-1:0] w_beat_next;
    logic [LINE_BITS-1:0]  r_wr_buf;
    logic [LINE_BITS-1:0]  r_rd_line;
    logic [ADDR_W-1:0]     r_host_addr;
    logic                  w_accept;
    logic                  w_beat_hs;
    logic                  w_last_beat;
    logic                  w_timeout;

    assign w_accept    = (r_state == ST_IDLE) &&
                         ((bus.mem_op == MEM_READ) || (bus.mem_op == MEM_WRITE));
    assign w_beat_hs   = ((r_state == ST_RD_BEAT) && bus.host_rd_valid) ||
                         ((r_state == ST_WR_BEAT) && bus.host_wr_ack);
    assign w_last_beat = w_beat_hs && (r_beat == BEAT_IDX_W'(BEATS - 1));

`ifdef MEM_CTRL_TIMEOUT_EN
    logic w_wdog_active;
    logic w_wdog_clear;

    assign w_wdog_active = (r_state == ST_RD_REQ) || (r_state == ST_RD_BEAT) ||
                           (r_state == ST_WR_REQ) || (r_state == ST_WR_BEAT);
    assign w_wdog_clear  = (w_state_next != r_state) || w_beat_hs;

    mem_ctrl_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (w_wdog_active),
        .i_clear  (w_wdog_clear),
        .o_expire (w_timeout)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a timeout wins over a same-cycle grant or beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_op == MEM_READ) begin
                    w_state_next = ST_RD_REQ;
                end else if (bus.mem_op == MEM_WRITE) begin
                    w_state_next = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (bus.host_gnt) begin
                    w_state_next = ST_RD_BEAT;
                end
            end
            ST_RD_BEAT: begin
                if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (bus.host_gnt) begin
                    w_state_next = ST_WR_BEAT;
                end
            end
            ST_WR_BEAT: begin
                if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Beat index: advances on each handshake, wraps 7->0, cleared on abort.
    always_comb begin
        w_beat_next = r_beat;
        if (w_timeout) begin
            w_beat_next = '0;
        end else if (w_beat_hs) begin
            w_beat_next = r_beat + BEAT_IDX_W'(1);
        end
    end

    // Datapath registers: address/line capture at accept, read beats into rd_line.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_beat      <= '0;
            r_host_addr <= '0;
            r_wr_buf    <= '0;
            r_rd_line   <= '0;
        end else begin
            r_beat <= w_beat_next;
            if (w_accept) begin
                r_host_addr <= line_align(bus.cpu_addr);
                r_wr_buf    <= bus.wr_line;
            end
            if ((r_state == ST_RD_BEAT) && bus.host_rd_valid && !w_timeout) begin
                r_rd_line[int'(r_beat)*BEAT_BITS +: BEAT_BITS] <= bus.host_rd_data;
            end
        end
    end

    assign bus.ready        = (r_state == ST_IDLE);
    assign bus.tx_done      = (r_state == ST_DONE);
    assign bus.tx_err       = w_timeout;
    assign bus.host_rd_req  = (r_state == ST_RD_REQ) && !w_timeout;
    assign bus.host_wr_req  = (r_state == ST_WR_REQ) && !w_timeout;
    assign bus.host_addr    = r_host_addr;
    assign bus.rd_line      = r_rd_line;
    assign bus.host_wr_data = (r_state == ST_WR_BEAT) ?
                              r_wr_buf[int'(r_beat)*BEAT_BITS +: BEAT_BITS] : '0;
    assign bus.dbg_state    = r_state;
    assign bus.dbg_beat     = r_beat;

endmodule
